// File: rtl/shift_sequencer.sv
// Multi-cycle shifter for SLL / SRA / ROR: one bit position per clock,
// counting the shift amount down, with a start/busy/done handshake.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for start; data register holds the last result
//   RUN   | shifting one bit per clock while cnt counts down to 1
//   DONE  | result valid for exactly one cycle (err set for mode 11)
module shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] opnd,
  input  logic [AMT_W-1:0] amt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRA = 2'b01;
  localparam logic [1:0] MODE_ROR = 2'b10;
  localparam logic [1:0] MODE_BAD = 2'b11;

  state_t           state;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] step;
  logic [AMT_W-1:0] cnt;
  logic [1:0]       mode_q;

  // One-bit step of the data register according to the latched mode.
  always_comb begin
    step = data;
    case (mode_q)
      MODE_SLL: step = {data[WIDTH-2:0], 1'b0};
      MODE_SRA: step = {data[WIDTH-1], data[WIDTH-1:1]};
      MODE_ROR: step = {data[0], data[WIDTH-1:1]};
      default:  step = data;
    endcase
  end

  // Sequencer FSM with the datapath registers and Moore-registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      data   <= '0;
      cnt    <= '0;
      mode_q <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            data   <= opnd;
            mode_q <= mode;
            cnt    <= amt;
            busy   <= 1'b1;
            if (mode == MODE_BAD) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else if (amt == '0) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b0;
            end else begin
              state <= RUN;
              done  <= 1'b0;
              err   <= 1'b0;
            end
          end
        end
        RUN: begin
          data <= step;
          cnt  <= cnt - AMT_W'(1);
          // cnt==1 is the last step, so cnt never wraps below zero
          if (cnt == AMT_W'(1)) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          err   <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          err   <= 1'b0;
        end
      endcase
    end
  end

  assign result = data;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: stimulus pushes expected results,
// a negedge monitor pops and compares whenever done is seen.
module tb_shift_sequencer;

  localparam int WIDTH = 16;
  localparam int AMT_W = 4;

  logic             clk;
  logic             rst;
  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] opnd;
  logic [AMT_W-1:0] amt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             err;

  shift_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mode   (mode),
    .opnd   (opnd),
    .amt    (amt),
    .busy   (busy),
    .done   (done),
    .result (result),
    .err    (err)
  );

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             e;
    int               done_cyc;
    int               blen;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   busy_run = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: whole-operation result computed directly from the shift rules.
  function automatic logic [WIDTH-1:0] ref_shift(input logic [1:0] m, input logic [WIDTH-1:0] o,
                                                  input int a);
    logic [2*WIDTH-1:0] dbl;
    logic signed [WIDTH-1:0] s;
    case (m)
      2'b00: return o << a;
      2'b01: begin s = o; return WIDTH'(s >>> a); end
      2'b10: begin dbl = {o, o}; dbl = dbl >> a; return dbl[WIDTH-1:0]; end
      default: return o;
    endcase
  endfunction

  function automatic int lat_of(input logic [1:0] m, input int a);
    return (m == 2'b11 || a == 0) ? 0 : a;
  endfunction

  // Monitor: pop expectation on each done and compare value, flag, timing, busy span.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      else busy_run = 0;
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = sb.pop_front();
          check("result", 32'(result), 32'(e.res));
          check("err", 32'(err), 32'(e.e));
          check("done_cycle", 32'(cyc), 32'(e.done_cyc));
          check("busy_span", 32'(busy_run), 32'(e.blen));
        end
      end else begin
        check("err_without_done", 32'(err), 32'd0);
      end
    end
  end

  // Called at a negedge; waits (bounded) for the sequencer to be idle.
  task automatic wait_idle();
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic push_exp(input logic [1:0] m, input logic [WIDTH-1:0] o, input int a,
                          input int e0);
    exp_t e;
    e.res      = ref_shift(m, o, a);
    e.e        = (m == 2'b11);
    e.done_cyc = e0 + lat_of(m, a);
    e.blen     = lat_of(m, a) + 1;
    sb.push_back(e);
  endtask

  // Issue one operation; after E0 the inputs are scrambled to prove they are ignored.
  task automatic issue(input logic [1:0] m, input logic [WIDTH-1:0] o, input int a);
    wait_idle();
    start = 1'b1;
    mode  = m;
    opnd  = o;
    amt   = AMT_W'(a);
    push_exp(m, o, a, cyc + 1);
    @(negedge clk);
    start = 1'b0;
    mode  = 2'($urandom);
    opnd  = WIDTH'($urandom);
    amt   = AMT_W'($urandom);
  endtask

  task automatic drain();
    wait_idle();
    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int adone;
    rst   = 1'b1;
    start = 1'b0;
    mode  = 2'b00;
    opnd  = '0;
    amt   = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    issue(2'b00, 16'h0001, 4);
    issue(2'b01, 16'h8000, 15);
    issue(2'b01, 16'h4000, 14);
    issue(2'b10, 16'h0001, 1);
    issue(2'b10, 16'h1234, 4);
    issue(2'b00, 16'hBEEF, 0);
    issue(2'b01, 16'hBEEF, 0);
    issue(2'b10, 16'hBEEF, 0);
    issue(2'b11, 16'h00AA, 5);
    issue(2'b00, 16'hFFFF, 15);
    drain();
    check("hold_after_done", 32'(result), 32'h0000_8000);

    // Start pulses while running are ignored
    issue(2'b00, 16'h0003, 8);
    @(negedge clk);
    start = 1'b1; mode = 2'b10; opnd = 16'h5555; amt = 4'd2;
    repeat (2) @(negedge clk);
    start = 1'b0;
    drain();

    // Start held continuously: second op accepted the cycle after DONE
    wait_idle();
    start = 1'b1; mode = 2'b10; opnd = 16'h1234; amt = 4'd3;
    adone = cyc + 1 + 3;
    push_exp(2'b10, 16'h1234, 3, cyc + 1);
    push_exp(2'b01, 16'hF00F, 5, adone + 2);
    @(negedge clk);
    mode = 2'b01; opnd = 16'hF00F; amt = 4'd5;
    for (int i = 0; i < 50 && cyc < adone + 2; i++) @(negedge clk);
    start = 1'b0;
    mode = 2'($urandom); opnd = WIDTH'($urandom); amt = AMT_W'($urandom);
    drain();

    // Reset mid-run discards the op with no done pulse
    issue(2'b00, 16'hFFFF, 10);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check("midrun_rst_busy", 32'(busy), 32'd0);
    check("midrun_rst_done", 32'(done), 32'd0);
    check("midrun_rst_result", 32'(result), 32'd0);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    issue(2'b10, 16'h00F1, 7);
    drain();

    // Randomized operations with random idle gaps
    for (int n = 0; n < 150; n++) begin
      issue(2'($urandom), WIDTH'($urandom), int'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
